// File: rtl/systolic_skew_feeder.sv
// Skewed west/north feeder for a SIZE x SIZE output-stationary systolic array.
// Optional stall counter output enabled with `define SKEW_FEEDER_STALL_CNT_EN.

module systolic_skew_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_act,
  input  logic [DW-1:0] i_wgt,
  output logic          o_vld,
  output logic [DW-1:0] o_act,
  output logic [DW-1:0] o_wgt
);
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][DW-1:0] r_act;
  logic [DEPTH-1:0][DW-1:0] r_wgt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_act <= '0;
      r_wgt <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_act[0] <= i_act;
      r_wgt[0] <= i_wgt;
      for (int j = 1; j < DEPTH; j++) begin
        r_vld[j] <= r_vld[j-1];
        r_act[j] <= r_act[j-1];
        r_wgt[j] <= r_wgt[j-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_act = r_act[DEPTH-1];
  assign o_wgt = r_wgt[DEPTH-1];
endmodule

module systolic_skew_feeder #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 16,
  parameter int PE_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_act,
  input  logic [SIZE*DATA_WIDTH-1:0] in_wgt,
  output logic [SIZE*DATA_WIDTH-1:0] west_inputs,
  output logic [SIZE-1:0]            west_valid,
  output logic [SIZE*DATA_WIDTH-1:0] north_inputs,
  output logic [SIZE-1:0]            north_valid,
  output logic                       accum_reset,
  output logic                       busy,
`ifdef SKEW_FEEDER_STALL_CNT_EN
  output logic [31:0]                stall_cycles,
`endif
  output logic                       done
);
  // Last lane drains 2*SIZE-1 cycles after the final accept, plus PE update time.
  localparam int FLUSH_CYC = 2*SIZE - 1 + PE_LATENCY;
  localparam int FW        = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [K_WIDTH-1:0] r_k_len;
  logic [K_WIDTH-1:0] r_k_cnt;
  logic [FW-1:0]      r_fl_cnt;
  logic               w_acc;

  logic [SIZE-1:0][DATA_WIDTH-1:0] w_act_inj, w_wgt_inj;
  logic [SIZE-1:0][DATA_WIDTH-1:0] w_west, w_north;
  logic [SIZE-1:0]                 w_wvld;

  assign w_acc = in_valid & in_ready;
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_k_len  <= '0;
      r_k_cnt  <= '0;
      r_fl_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) r_k_len <= k_len;
      if (r_state == S_CLEAR) begin
        r_k_cnt  <= '0;
        r_fl_cnt <= '0;
      end
      if (r_state == S_STREAM && w_acc) r_k_cnt <= r_k_cnt + K_WIDTH'(1);
      if (r_state == S_FLUSH) r_fl_cnt <= r_fl_cnt + FW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    accum_reset = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        accum_reset = 1'b1;
        w_state_nxt = (r_k_len != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && (r_k_cnt + K_WIDTH'(1)) == r_k_len) w_state_nxt = S_FLUSH;
      end
      S_FLUSH:  if (r_fl_cnt == FW'(FLUSH_CYC - 1)) w_state_nxt = S_DONE;
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Non-accept cycles inject zero bubbles so data and valid share one skew path.
  assign w_act_inj = w_acc ? in_act : '0;
  assign w_wgt_inj = w_acc ? in_wgt : '0;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    systolic_skew_lane #(.DW(DATA_WIDTH), .DEPTH(gi + 1)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_vld (w_acc),
      .i_act (w_act_inj[gi]),
      .i_wgt (w_wgt_inj[gi]),
      .o_vld (w_wvld[gi]),
      .o_act (w_west[gi]),
      .o_wgt (w_north[gi])
    );
  end

  assign west_inputs  = w_west;
  assign north_inputs = w_north;
  assign west_valid   = w_wvld;
  assign north_valid  = w_wvld;

`ifdef SKEW_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                  stall_cycles <= '0;
    else if (r_state == S_CLEAR)                               stall_cycles <= '0;
    else if (r_state == S_STREAM && !in_valid && stall_cycles != '1)
                                                               stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench: timeline/skew reference model plus end-to-end matrix product check.
module tb_systolic_skew_feeder;
  localparam int SIZE = 4, DW = 8, KW = 16, PEL = 1;
  localparam int MAXC = 4096, MAXK = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic [SIZE*DW-1:0] in_act = '0, in_wgt = '0;
  logic               in_ready, accum_reset, busy, done;
  logic [SIZE*DW-1:0] west_inputs, north_inputs;
  logic [SIZE-1:0]    west_valid, north_valid;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  systolic_skew_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW), .PE_LATENCY(PEL)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .west_inputs(west_inputs), .west_valid(west_valid),
    .north_inputs(north_inputs), .north_valid(north_valid), .accum_reset(accum_reset),
    .busy(busy),
`ifdef SKEW_FEEDER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done));

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0, cyc = 0;
  // model: tile timeline as absolute cycle numbers
  int m_ts = -1, m_k = 0, m_cnt = 0, m_tlast = -1, m_done = -1;
  logic [31:0] m_stall = '0;
  logic              inj_v [MAXC];
  logic [SIZE*DW-1:0] inj_a [MAXC];
  logic [SIZE*DW-1:0] inj_w [MAXC];
  int sl_a [MAXK][SIZE], sl_w [MAXK][SIZE];
  int qa [SIZE][MAXK], qn [SIZE][MAXK], qa_n [SIZE], qn_n [SIZE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_hist();
    for (int i = 0; i < MAXC; i++) begin inj_v[i] = 0; inj_a[i] = '0; inj_w[i] = '0; end
  endtask

  task automatic clr_q();
    for (int i = 0; i < SIZE; i++) begin qa_n[i] = 0; qn_n[i] = 0; end
  endtask

  function automatic bit m_stream();
    return m_ts >= 0 && m_k != 0 && cyc >= m_ts + 2 && m_tlast < 0;
  endfunction

  task automatic tick(input logic v, input logic st, input logic [KW-1:0] kl,
                      input logic [SIZE*DW-1:0] a, input logic [SIZE*DW-1:0] w);
    bit idle_now, clr, strm, dn, acc;
    logic [SIZE-1:0] ev;
    logic [SIZE*DW-1:0] ea, ew;
    int idx, so, se;
    idle_now = (m_ts < 0);
    clr  = !idle_now && cyc == m_ts + 1;
    strm = m_stream();
    dn   = !idle_now && cyc == m_done;
    ev = '0; ea = '0; ew = '0;
    for (int i = 0; i < SIZE; i++) begin
      idx = cyc - 1 - i;
      if (idx >= 0 && inj_v[idx]) begin
        ev[i] = 1'b1;
        ea[i*DW +: DW] = inj_a[idx][i*DW +: DW];
        ew[i*DW +: DW] = inj_w[idx][i*DW +: DW];
      end
    end
    chk("in_ready", in_ready, strm);
    chk("accum_reset", accum_reset, clr);
    chk("busy", busy, !idle_now && cyc >= m_ts + 1);
    chk("done", done, dn);
    chk("west_valid", west_valid, ev);
    chk("north_valid", north_valid, ev);
    chk("west_data", west_inputs, ea);
    chk("north_data", north_inputs, ew);
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    for (int i = 0; i < SIZE; i++) begin
      if (west_valid[i] && qa_n[i] < MAXK) begin
        qa[i][qa_n[i]] = int'($signed(west_inputs[i*DW +: DW])); qa_n[i]++;
      end
      if (north_valid[i] && qn_n[i] < MAXK) begin
        qn[i][qn_n[i]] = int'($signed(north_inputs[i*DW +: DW])); qn_n[i]++;
      end
    end
    if (dn) begin
      // results an output-stationary array would hold: sum over k of A[r][k]*B[k][c]
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) begin
          so = 0; se = 0;
          for (int j = 0; j < qa_n[r] && j < qn_n[c]; j++) so += qa[r][j] * qn[c][j];
          for (int j = 0; j < m_k && j < MAXK; j++) se += sl_a[j][r] * sl_w[j][c];
          chk("e2e_result", so, se);
        end
      clr_q();
    end
    in_valid = v; start = st; k_len = kl; in_act = a; in_wgt = w;
    acc = v && strm;
    inj_v[cyc] = acc;
    inj_a[cyc] = acc ? a : '0;
    inj_w[cyc] = acc ? w : '0;
    if (acc) begin
      if (m_cnt < MAXK)
        for (int i = 0; i < SIZE; i++) begin
          sl_a[m_cnt][i] = int'($signed(a[i*DW +: DW]));
          sl_w[m_cnt][i] = int'($signed(w[i*DW +: DW]));
        end
      m_cnt++;
      if (m_cnt == m_k) begin m_tlast = cyc; m_done = cyc + 2*SIZE + PEL; end
    end
    if (clr) m_stall = '0;
    else if (strm && !v && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (dn) m_ts = -1;
    if (idle_now && st) begin
      m_ts = cyc; m_k = int'(kl); m_cnt = 0; m_tlast = -1;
      m_done = (kl == 0) ? cyc + 2 : -1;
      clr_q();
    end
    @(posedge clk); cyc++; #1;
  endtask

  // mode 0 random data, 1 identity/ramp, 2 identity/-1; pat: per-offer valid bits, 0 = random
  task automatic run_tile(input int k, input int mode, input logic [31:0] pat, input bit noise);
    logic [SIZE*DW-1:0] a, w;
    int off;
    logic v, st;
    logic [KW-1:0] kl;
    off = 0;
    tick(1'b0, 1'b1, KW'(k), '0, '0);
    for (int n = 0; n < 300 && m_ts >= 0; n++) begin
      a = '0; w = '0;
      for (int i = 0; i < SIZE; i++) begin
        case (mode)
          1: begin a[i*DW +: DW] = (i == m_cnt) ? 8'd1 : 8'd0; w[i*DW +: DW] = DW'(m_cnt*SIZE + i); end
          2: begin a[i*DW +: DW] = (i == m_cnt) ? 8'd1 : 8'd0; w[i*DW +: DW] = 8'hFF; end
          default: begin a[i*DW +: DW] = DW'($urandom); w[i*DW +: DW] = DW'($urandom); end
        endcase
      end
      v = 1'b0;
      if (m_stream()) begin
        v = (pat != 0) ? pat[off] : ($urandom_range(0, 2) != 0);
        off++;
      end
      st = noise && ($urandom_range(0, 3) == 0);
      kl = noise ? KW'($urandom_range(0, 9)) : '0;
      tick(v, st, kl, a, w);
    end
    chk("tile_timeout", m_ts >= 0, 1'b0);
    m_ts = -1;
    tick(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    clr_hist(); clr_q();
    repeat (3) begin @(posedge clk); cyc++; end
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_accum_reset", accum_reset, 1'b0);
    chk("rst_valid", {west_valid, north_valid}, '0);
    rst = 1'b1;
    tick(1'b0, 1'b0, '0, '0, '0);

    run_tile(4, 1, 32'hFFFF_FFFF, 1'b0);   // identity x ramp, continuous
    run_tile(4, 2, 32'hFFFF_FFFF, 1'b0);   // all -1: no stale accumulation
    run_tile(3, 0, 32'b10101, 1'b0);       // bubbles 1,0,1,0,1
    run_tile(0, 0, 32'h0, 1'b0);           // empty tile
    run_tile(5, 0, 32'hFFFF_FFFF, 1'b1);   // start/k_len noise while busy

    // reset mid-stream
    tick(1'b0, 1'b1, KW'(5), '0, '0);
    repeat (3) tick(1'b1, 1'b0, '0, {SIZE*DW{1'b1}}, {SIZE*DW{1'b1}});
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {west_valid, north_valid}, '0);
    chk("mid_rst_accum_reset", accum_reset, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    m_ts = -1; m_tlast = -1; m_done = -1; m_stall = '0;
    clr_hist(); clr_q();
    @(posedge clk); cyc++; #1;
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0, '0, '0, '0);

    for (int t = 0; t < 20; t++)
      run_tile($urandom_range(0, 8), 0, 32'h0, t[0]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
